ddr_burst_tester: RTL and testbench
===================================

# ddr_burst_tester

Self-checking traffic generator sitting directly upstream of `mem_burst_v2` in the DDR test design. It repeatedly writes a `BURST_LEN`-word burst of a deterministic pattern, reads the same burst back, and compares every returned word against a regenerated expected value. The address then advances, wrapping at `TEST_DEPTH`. Error status and counters are exported to LEDs or a debug probe.

## Interface
Parameters:
- `MEM_DATA_BITS`, 32: data width; must match `mem_burst_v2`.
- `ADDR_BITS`, 24: address width in words.
- `BURST_LEN`, 10'd128: words per burst; legal range 1..1023.
- `TEST_DEPTH`, 24'd4096: words covered before the address wraps; must be ≥ `BURST_LEN`.

Ports:
- `mem_clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `local_init_done` in 1: DDR calibration complete.
- `test_en` in 1: run enable, level-sensitive.
- `wr_burst_req` out 1: write burst request.
- `wr_burst_len` out 10: constant `BURST_LEN`.
- `wr_burst_addr` out `ADDR_BITS`: write start address.
- `wr_burst_data_req` in 1: downstream wants the next write word.
- `wr_burst_data` out `MEM_DATA_BITS`: write word, registered.
- `wr_burst_finish` in 1: last write word accepted.
- `rd_burst_req` out 1: read burst request.
- `rd_burst_len` out 10: constant `BURST_LEN`.
- `rd_burst_addr` out `ADDR_BITS`: read start address.
- `rd_burst_data_valid` in 1: read word valid.
- `rd_burst_data` in `MEM_DATA_BITS`: read word.
- `rd_burst_finish` in 1: last read word returned.
- `error` out 1: sticky mismatch flag.
- `err_cnt` out 16: saturating count of mismatched words and length errors.
- `burst_cnt` out 16: wrapping count of completed write/read pairs.

## Operation
States:
- `IDLE`: no requests asserted. Moves to `WRITE` when `local_init_done && test_en`.
- `WRITE`: `wr_burst_req`=1. On `wr_burst_finish` moves to `READ`. `wr_burst_finish` is ignored in every other state, because the downstream block can raise it spuriously.
- `READ`: `rd_burst_req`=1. On `rd_burst_finish` moves to `NEXT`. `rd_burst_finish` is ignored in every other state.
- `NEXT`: one cycle. Increments `burst_cnt`. Sets `cur_addr` = (`cur_addr` + `BURST_LEN` > `TEST_DEPTH` − `BURST_LEN`) ? 0 : `cur_addr` + `BURST_LEN`. Then moves to `WRITE` if `test_en`, otherwise to `IDLE`.

Address rules:
- `local_init_done`=0 in any state forces `IDLE` on the next edge. Requests drop, and `cur_addr`, the word counters and the status outputs are all kept.
- `wr_burst_addr` = `rd_burst_addr` = `cur_addr`, which is held constant while a request is high.

Pattern:
- The pattern word for index i of the burst at address A is P(A, i) = zero-extend(A + i). Arithmetic is modulo 2^`MEM_DATA_BITS`.

Checking:
- In `READ`, every `rd_burst_data_valid` beat compares `rd_burst_data` against P(`cur_addr`, `rd_idx`) and then increments `rd_idx`.
- On a mismatch: `error` is set, and `err_cnt` increments, saturating at 16'hFFFF.
- On `rd_burst_finish`, a length error is also counted if `rd_idx` including the current beat ≠ `BURST_LEN`.
- The `rd_idx` and `wr_idx` counters clear on entry to `WRITE`.
- `error` clears only on reset.

## Timing
Reset values:
- All outputs are 0 except `wr_burst_len`/`rd_burst_len` (`BURST_LEN`).
- `cur_addr`=0 and state=`IDLE`.

Request handshake:
- Requests are registered.
- A request rises on the edge of the state entry and falls on the edge at which the matching finish is sampled.
- Write to read turnaround: `rd_burst_req` is high on the cycle after `wr_burst_finish`. The write and read requests are never high together.

Write data:
- `wr_burst_data` is loaded one cycle after each `wr_burst_data_req` with P(`cur_addr`, `wr_idx`), and `wr_idx` increments.
- The first load (`wr_idx`=0) occurs on the cycle after the first request, which matches the downstream block capturing data one cycle after its request.
- `wr_burst_data_req` pulses after `BURST_LEN` requests are ignored.

Read check:
- Check latency is 0: the comparison is made on the beat itself.
- `error` and `err_cnt` update one cycle after the offending beat.

Other timing:
- `NEXT` to `WRITE`: `wr_burst_req` rises one cycle after `NEXT`.
- Reset mid-burst: all outputs return to their reset values asynchronously.

## Configuration
`DDR_TEST_LFSR_PATTERN_EN`: LFSR pattern mode.
- Defined:
  - P is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, advanced once per word.
  - It is seeded per burst with zero-extend(A) ^ 32'h5A5A_5A5A; a seed of 0 is replaced by 1.
  - This mode requires `MEM_DATA_BITS`=32.
- Undefined: the incrementing pattern described above. No LFSR logic is generated.

## Structure
- Package `ddr_test_pkg`: state encoding (`IDLE`, `WRITE`, `READ`, `NEXT`), LFSR polynomial and seed constants, `err_cnt` saturation value.
- Sub-module `ddr_test_pattern_gen`, instantiated twice (write side and expected side):
  - Inputs: `load`, `base_addr`, `advance`.
  - Output: the current pattern word.
  - Contains the only `DDR_TEST_LFSR_PATTERN_EN`-conditional logic.

## Test plan
- Release reset with `local_init_done`=0 and `test_en`=1 → no request for 100 cycles. Raise `local_init_done` → `wr_burst_req`=1 the next cycle with `wr_burst_addr`=0.
- Behavioural `mem_burst_v2`/DDR model, `BURST_LEN`=4, 4 write/read pairs → written words 0,1,2,3 / 4,5,6,7 / …; `error`=0, `err_cnt`=0, `burst_cnt`=4.
- Model corrupts read word 2 of burst at address 8 (bit 0 flipped) → `error`=1 one cycle later, `err_cnt`=1, testing continues.
- `TEST_DEPTH`=8, `BURST_LEN`=4 → addresses 0, 4, 0, 4…
- Assert `wr_burst_finish` while in `READ` or `IDLE` → ignored. Assert `rd_burst_finish` after only 3 of 4 beats → `err_cnt`+1.
- Pulse `rst_n` low during `READ` → all outputs are at their reset values immediately. Restart resumes from address 0.

Source files
------------

// File: rtl/ddr_test_pkg.sv
// ============================================================================
// Module      : ddr_test_pkg
// Description : Shared definitions for the DDR burst tester: state encoding,
//               LFSR polynomial and seed constants, error counter ceiling.
//               The LFSR helpers are only used when DDR_TEST_LFSR_PATTERN_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_test_pkg;

   // Tester sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      NEXT  = 2'd3
   } test_state_t;

   // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
   localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
   // XORed with the burst address to seed each burst
   localparam logic [31:0] LFSR_SEED_XOR = 32'h5A5A_5A5A;
   // err_cnt saturates here
   localparam logic [15:0] ERR_CNT_MAX   = 16'hFFFF;

   // One Galois LFSR step
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_test_pattern_gen.sv
// ============================================================================
// Module      : ddr_test_pattern_gen
// Description : Pattern word source. 'load' restarts the sequence for a burst
//               at base_addr, 'advance' steps to the next word. Default build
//               produces zero-extend(base_addr + i); with
//               DDR_TEST_LFSR_PATTERN_EN defined it produces a 32-bit Galois
//               LFSR sequence seeded from the address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_test_pattern_gen
   import ddr_test_pkg::*;
#(
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 24
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [ADDR_BITS-1:0]     base_addr,
   input  logic                     advance,
   output logic [MEM_DATA_BITS-1:0] pattern
);

`ifdef DDR_TEST_LFSR_PATTERN_EN
   logic [31:0] w_seed;
   logic [31:0] r_lfsr;

   // An all-zero state would lock the LFSR, so substitute 1
   assign w_seed = 32'(base_addr) ^ LFSR_SEED_XOR;

   // LFSR state: reseed per burst, step once per consumed word
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 32'd1;
      end else if (load) begin
         r_lfsr <= (w_seed == 32'd0) ? 32'd1 : w_seed;
      end else if (advance) begin
         r_lfsr <= lfsr_step(r_lfsr);
      end
   end

   assign pattern = MEM_DATA_BITS'(r_lfsr);
`else
   logic [MEM_DATA_BITS-1:0] r_word;

   // Incrementing word: start at the burst address, +1 per consumed word
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
      end else if (load) begin
         r_word <= MEM_DATA_BITS'(base_addr);
      end else if (advance) begin
         r_word <= r_word + MEM_DATA_BITS'(1);
      end
   end

   assign pattern = r_word;
`endif

endmodule

`default_nettype wire

// File: rtl/ddr_burst_tester.sv
// ============================================================================
// Module      : ddr_burst_tester
// Description : Self-checking DDR traffic generator. Writes a BURST_LEN-word
//               pattern burst, reads it back, compares every word, then
//               advances the address (wrapping at TEST_DEPTH). Exports a
//               sticky error flag, a saturating error count and a burst count.
//               Optional macro DDR_TEST_LFSR_PATTERN_EN selects LFSR data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_burst_tester
   import ddr_test_pkg::*;
#(
   parameter int          MEM_DATA_BITS = 32,
   parameter int          ADDR_BITS     = 24,
   parameter logic [9:0]  BURST_LEN     = 10'd128,
   parameter logic [23:0] TEST_DEPTH    = 24'd4096
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic                     local_init_done,
   input  logic                     test_en,
   output logic                     wr_burst_req,
   output logic [9:0]               wr_burst_len,
   output logic [ADDR_BITS-1:0]     wr_burst_addr,
   input  logic                     wr_burst_data_req,
   output logic [MEM_DATA_BITS-1:0] wr_burst_data,
   input  logic                     wr_burst_finish,
   output logic                     rd_burst_req,
   output logic [9:0]               rd_burst_len,
   output logic [ADDR_BITS-1:0]     rd_burst_addr,
   input  logic                     rd_burst_data_valid,
   input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
   input  logic                     rd_burst_finish,
   output logic                     error,
   output logic [15:0]              err_cnt,
   output logic [15:0]              burst_cnt
);

   // One spare bit so the wrap test cannot overflow
   localparam int AW1      = ADDR_BITS + 1;
   // Beat counters are wide enough to count past 1023 stray beats
   localparam int IDX_BITS = 11;

   test_state_t              r_state;
   test_state_t              w_state_nxt;
   logic [ADDR_BITS-1:0]     r_cur_addr;
   logic [IDX_BITS-1:0]      r_wr_idx;
   logic [IDX_BITS-1:0]      r_rd_idx;
   logic                     r_wr_req;
   logic                     r_rd_req;
   logic [MEM_DATA_BITS-1:0] r_wr_data;
   logic                     r_error;
   logic [15:0]              r_err_cnt;
   logic [15:0]              r_burst_cnt;

   logic                     w_enter_write;
   logic                     w_wr_accept;
   logic                     w_rd_beat;
   logic                     w_mismatch;
   logic                     w_len_err;
   logic [IDX_BITS-1:0]      w_rd_count;
   logic [AW1-1:0]           w_addr_sum;
   logic [AW1-1:0]           w_wrap_limit;
   logic [ADDR_BITS-1:0]     w_addr_step;
   logic [ADDR_BITS-1:0]     w_load_addr;
   logic [MEM_DATA_BITS-1:0] w_wr_pattern;
   logic [MEM_DATA_BITS-1:0] w_exp_pattern;
   logic [1:0]               w_err_inc;
   logic [16:0]              w_err_sum;

   // State register
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; finish strobes only count in their own state,
   // and losing calibration overrides everything
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (local_init_done && test_en) w_state_nxt = WRITE;
         WRITE:   if (wr_burst_finish)            w_state_nxt = READ;
         READ:    if (rd_burst_finish)            w_state_nxt = NEXT;
         NEXT:    w_state_nxt = test_en ? WRITE : IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (!local_init_done) begin
         w_state_nxt = IDLE;
      end
   end

   // Address advance: wrap to 0 once the next burst would run past TEST_DEPTH
   assign w_addr_sum    = AW1'(r_cur_addr) + AW1'(BURST_LEN);
   assign w_wrap_limit  = AW1'(TEST_DEPTH) - AW1'(BURST_LEN);
   assign w_addr_step   = (w_addr_sum > w_wrap_limit) ? '0 : w_addr_sum[ADDR_BITS-1:0];
   // Address the upcoming burst will use, valid on the entry edge
   assign w_load_addr   = (r_state == NEXT) ? w_addr_step : r_cur_addr;
   assign w_enter_write = (w_state_nxt == WRITE) && (r_state != WRITE);

   // Data requests beyond BURST_LEN are dropped
   assign w_wr_accept = (r_state == WRITE) && wr_burst_data_req
                        && (r_wr_idx < IDX_BITS'(BURST_LEN));
   assign w_rd_beat   = (r_state == READ) && rd_burst_data_valid;
   assign w_mismatch  = w_rd_beat && (rd_burst_data != w_exp_pattern);
   // Beats seen so far including the one on this cycle
   assign w_rd_count  = r_rd_idx + IDX_BITS'(w_rd_beat);
   assign w_len_err   = (r_state == READ) && rd_burst_finish
                        && (w_rd_count != IDX_BITS'(BURST_LEN));
   // A short final beat can be both a mismatch and a length error
   assign w_err_inc   = {1'b0, w_mismatch} + {1'b0, w_len_err};
   assign w_err_sum   = {1'b0, r_err_cnt} + 17'(w_err_inc);

   // Write-side pattern source
   ddr_test_pattern_gen #(
      .MEM_DATA_BITS (MEM_DATA_BITS),
      .ADDR_BITS     (ADDR_BITS)
   ) u_wr_pattern (
      .mem_clk   (mem_clk),
      .rst_n     (rst_n),
      .load      (w_enter_write),
      .base_addr (w_load_addr),
      .advance   (w_wr_accept),
      .pattern   (w_wr_pattern)
   );

   // Expected-data pattern source for the read check
   ddr_test_pattern_gen #(
      .MEM_DATA_BITS (MEM_DATA_BITS),
      .ADDR_BITS     (ADDR_BITS)
   ) u_exp_pattern (
      .mem_clk   (mem_clk),
      .rst_n     (rst_n),
      .load      (w_enter_write),
      .base_addr (w_load_addr),
      .advance   (w_rd_beat),
      .pattern   (w_exp_pattern)
   );

   // Registered requests track the state being entered
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_req <= 1'b0;
         r_rd_req <= 1'b0;
      end else begin
         r_wr_req <= (w_state_nxt == WRITE);
         r_rd_req <= (w_state_nxt == READ);
      end
   end

   // Burst address and completed-pair count move only in NEXT
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_addr  <= '0;
         r_burst_cnt <= '0;
      end else if (r_state == NEXT) begin
         r_cur_addr  <= w_addr_step;
         r_burst_cnt <= r_burst_cnt + 16'd1;
      end
   end

   // Write word counter and registered write data
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx  <= '0;
         r_wr_data <= '0;
      end else if (w_enter_write) begin
         r_wr_idx  <= '0;
      end else if (w_wr_accept) begin
         r_wr_idx  <= r_wr_idx + IDX_BITS'(1);
         r_wr_data <= w_wr_pattern;
      end
   end

   // Read beat counter
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_idx <= '0;
      end else if (w_enter_write) begin
         r_rd_idx <= '0;
      end else if (w_rd_beat) begin
         r_rd_idx <= r_rd_idx + IDX_BITS'(1);
      end
   end

   // Sticky error flag and saturating error counter
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_error   <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_mismatch) begin
            r_error <= 1'b1;
         end
         r_err_cnt <= (w_err_sum > 17'(ERR_CNT_MAX)) ? ERR_CNT_MAX : w_err_sum[15:0];
      end
   end

   assign wr_burst_req  = r_wr_req;
   assign rd_burst_req  = r_rd_req;
   assign wr_burst_len  = BURST_LEN;
   assign rd_burst_len  = BURST_LEN;
   assign wr_burst_addr = r_cur_addr;
   assign rd_burst_addr = r_cur_addr;
   assign wr_burst_data = r_wr_data;
   assign error         = r_error;
   assign err_cnt       = r_err_cnt;
   assign burst_cnt     = r_burst_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ddr_burst_tester.sv
// ============================================================================
// Module      : tb_ddr_burst_tester
// Description : Directed bench for ddr_burst_tester (BURST_LEN=4,
//               TEST_DEPTH=16) with a small behavioural memory acting as the
//               downstream burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_burst_tester;

   localparam int BL = 4;

   logic        mem_clk = 1'b0;
   logic        rst_n;
   logic        local_init_done;
   logic        test_en;
   logic        wr_burst_data_req;
   logic        wr_burst_finish;
   logic        rd_burst_data_valid;
   logic [31:0] rd_burst_data;
   logic        rd_burst_finish;

   logic        wr_burst_req;
   logic [9:0]  wr_burst_len;
   logic [23:0] wr_burst_addr;
   logic [31:0] wr_burst_data;
   logic        rd_burst_req;
   logic [9:0]  rd_burst_len;
   logic [23:0] rd_burst_addr;
   logic        error;
   logic [15:0] err_cnt;
   logic [15:0] burst_cnt;

   logic [31:0] mem [16];
   int          n_vec = 0;
   int          n_err = 0;
   logic        seen;

   ddr_burst_tester #(
      .MEM_DATA_BITS (32),
      .ADDR_BITS     (24),
      .BURST_LEN     (10'd4),
      .TEST_DEPTH    (24'd16)
   ) dut (
      .mem_clk             (mem_clk),
      .rst_n               (rst_n),
      .local_init_done     (local_init_done),
      .test_en             (test_en),
      .wr_burst_req        (wr_burst_req),
      .wr_burst_len        (wr_burst_len),
      .wr_burst_addr       (wr_burst_addr),
      .wr_burst_data_req   (wr_burst_data_req),
      .wr_burst_data       (wr_burst_data),
      .wr_burst_finish     (wr_burst_finish),
      .rd_burst_req        (rd_burst_req),
      .rd_burst_len        (rd_burst_len),
      .rd_burst_addr       (rd_burst_addr),
      .rd_burst_data_valid (rd_burst_data_valid),
      .rd_burst_data       (rd_burst_data),
      .rd_burst_finish     (rd_burst_finish),
      .error               (error),
      .err_cnt             (err_cnt),
      .burst_cnt           (burst_cnt)
   );

   always #5 mem_clk = ~mem_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for a write request, then check its address
   task automatic wait_wr_req(input int addr);
      int n = 0;
      while (wr_burst_req !== 1'b1 && n < 50) begin
         @(negedge mem_clk);
         n++;
      end
      check("wr_req_seen", 32'(wr_burst_req), 32'd1);
      check("wr_addr", 32'(wr_burst_addr), 32'(addr));
      check("no_rd_during_wr", 32'(rd_burst_req), 32'd0);
   endtask

   // Downstream write: BL data requests, one extra ignored request, finish
   task automatic write_burst(input int addr);
      for (int i = 0; i < BL; i++) begin
         wr_burst_data_req = 1'b1;
         @(negedge mem_clk);
         wr_burst_data_req = 1'b0;
         @(negedge mem_clk);
         check("wr_data", wr_burst_data, 32'(addr + i));
         mem[addr + i] = wr_burst_data;
      end
      wr_burst_data_req = 1'b1;
      @(negedge mem_clk);
      wr_burst_data_req = 1'b0;
      @(negedge mem_clk);
      check("wr_data_extra_req_ignored", wr_burst_data, 32'(addr + BL - 1));
      wr_burst_finish = 1'b1;
      @(negedge mem_clk);
      wr_burst_finish = 1'b0;
      check("rd_req_after_wr_finish", 32'(rd_burst_req), 32'd1);
      check("wr_req_dropped", 32'(wr_burst_req), 32'd0);
      check("rd_addr", 32'(rd_burst_addr), 32'(addr));
   endtask

   // Downstream read: nbeats beats, finish on the last; optional bit-0
   // corruption of one beat and a stray wr_burst_finish on beat 0
   task automatic read_burst(input int addr, input int nbeats, input int corrupt, input bit spurious);
      for (int i = 0; i < nbeats; i++) begin
         rd_burst_data_valid = 1'b1;
         rd_burst_data       = mem[addr + i] ^ ((i == corrupt) ? 32'd1 : 32'd0);
         rd_burst_finish     = (i == nbeats - 1);
         wr_burst_finish     = spurious && (i == 0);
         if (i == corrupt) check("error_before_bad_beat", 32'(error), 32'd0);
         @(negedge mem_clk);
         wr_burst_finish = 1'b0;
         if (spurious && i == 0) begin
            check("stray_wr_finish_rd_req", 32'(rd_burst_req), 32'd1);
            check("stray_wr_finish_wr_req", 32'(wr_burst_req), 32'd0);
         end
         if (i == corrupt) check("error_after_bad_beat", 32'(error), 32'd1);
      end
      rd_burst_data_valid = 1'b0;
      rd_burst_finish     = 1'b0;
      check("no_req_in_next", 32'({wr_burst_req, rd_burst_req}), 32'd0);
   endtask

   task automatic do_pair(input int addr, input int exp_cnt, input int exp_err,
                          input int nbeats, input int corrupt, input bit spurious);
      wait_wr_req(addr);
      write_burst(addr);
      read_burst(addr, nbeats, corrupt, spurious);
      @(negedge mem_clk);
      check("burst_cnt", 32'(burst_cnt), 32'(exp_cnt));
      check("err_cnt", 32'(err_cnt), 32'(exp_err));
   endtask

   initial begin
      rst_n               = 1'b0;
      local_init_done     = 1'b0;
      test_en             = 1'b1;
      wr_burst_data_req   = 1'b0;
      wr_burst_finish     = 1'b0;
      rd_burst_data_valid = 1'b0;
      rd_burst_data       = 32'd0;
      rd_burst_finish     = 1'b0;
      repeat (3) @(negedge mem_clk);

      // Reset values
      check("rst_wr_req", 32'(wr_burst_req), 32'd0);
      check("rst_rd_req", 32'(rd_burst_req), 32'd0);
      check("rst_wr_len", 32'(wr_burst_len), 32'd4);
      check("rst_rd_len", 32'(rd_burst_len), 32'd4);
      check("rst_wr_addr", 32'(wr_burst_addr), 32'd0);
      check("rst_wr_data", wr_burst_data, 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_burst_cnt", 32'(burst_cnt), 32'd0);

      // No calibration: no requests, stray finishes in IDLE ignored
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wr_burst_finish = (i == 10);
         rd_burst_finish = (i == 20);
         @(negedge mem_clk);
         if (wr_burst_req || rd_burst_req) seen = 1'b1;
      end
      wr_burst_finish = 1'b0;
      rd_burst_finish = 1'b0;
      check("no_req_without_init", 32'(seen), 32'd0);

      local_init_done = 1'b1;
      @(negedge mem_clk);
      check("wr_req_after_init", 32'(wr_burst_req), 32'd1);
      check("wr_addr_after_init", 32'(wr_burst_addr), 32'd0);

      // Four clean pairs, then wrap back to 0
      do_pair(0,  1, 0, 4, -1, 1'b0);
      do_pair(4,  2, 0, 4, -1, 1'b0);
      do_pair(8,  3, 0, 4, -1, 1'b0);
      do_pair(12, 4, 0, 4, -1, 1'b0);
      check("clean_error", 32'(error), 32'd0);
      do_pair(0,  5, 0, 4, -1, 1'b1);
      do_pair(4,  6, 0, 4, -1, 1'b0);
      // Corrupted word 2 at address 8
      do_pair(8,  7, 1, 4, 2, 1'b0);
      check("error_sticky", 32'(error), 32'd1);
      do_pair(12, 8, 1, 4, -1, 1'b0);
      // Short read: finish after 3 of 4 beats
      do_pair(0,  9, 2, 3, -1, 1'b0);

      // Calibration lost mid-write: requests drop, address and counts kept
      local_init_done = 1'b0;
      @(negedge mem_clk);
      check("init_lost_wr_req", 32'(wr_burst_req), 32'd0);
      check("init_lost_addr", 32'(wr_burst_addr), 32'd4);
      check("init_lost_burst_cnt", 32'(burst_cnt), 32'd9);
      local_init_done = 1'b1;
      do_pair(4, 10, 2, 4, -1, 1'b0);

      // Asynchronous reset during READ
      wait_wr_req(8);
      write_burst(8);
      rst_n = 1'b0;
      #1;
      check("async_rst_rd_req", 32'(rd_burst_req), 32'd0);
      check("async_rst_wr_req", 32'(wr_burst_req), 32'd0);
      check("async_rst_error", 32'(error), 32'd0);
      check("async_rst_err_cnt", 32'(err_cnt), 32'd0);
      check("async_rst_burst_cnt", 32'(burst_cnt), 32'd0);
      check("async_rst_addr", 32'(rd_burst_addr), 32'd0);
      check("async_rst_wr_data", wr_burst_data, 32'd0);
      @(negedge mem_clk);
      rst_n = 1'b1;
      do_pair(0, 1, 0, 4, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
